// File: rtl/simple_mem_pkg.sv
// Shared types and helpers for the simple mem_req/mem_ack responder.
package simple_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Source feeding mem_rdata; the RAM output register holds its value between reads.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_ONES = 2'd2
    } rdata_src_e;

    localparam int unsigned MAX_DATA_WIDTH = 1024;
    localparam logic [MAX_DATA_WIDTH-1:0] ERR_RDATA = '1;

    function automatic int unsigned index_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/simple_mem_array.sv
// Single-port synchronous RAM with write enable and registered, enable-gated read.
module simple_mem_array #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset so the array maps onto block RAM; rdata_q only moves on a read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/simple_mem_responder.sv
// Bus target: accepts one mem_req at a time, serves it from internal RAM after
// WAIT_CYCLES wait states, pulses mem_ack, and flags bad addresses.
module simple_mem_responder
    import simple_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    input  logic                  err_clear,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int unsigned           SHIFT      = index_shift(DATA_WIDTH);
    localparam int unsigned           IDXW       = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH * (DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] ERR_FILL   = ERR_RDATA[DATA_WIDTH-1:0];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    rdata_src_e            src_q, src_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [31:0]           rd_count_q, rd_count_d;
    logic [31:0]           wr_count_q, wr_count_d;

    logic [ADDR_WIDTH-1:0] look_addr;
    logic [ADDR_WIDTH-1:0] look_off;
    logic                  look_we;
    logic                  look_valid;
    logic [IDXW-1:0]       look_idx;
    logic                  enter_ack;
    logic                  is_ack;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // In IDLE the live bus is decoded so a zero-wait read can hit the RAM on
    // the acceptance edge; otherwise the latched transaction is decoded.
    always_comb begin
        look_addr  = (state_q == IDLE) ? mem_addr : addr_q;
        look_we    = (state_q == IDLE) ? mem_we   : we_q;
        look_off   = look_addr - BASE_ADDR;
        look_valid = (look_addr >= BASE_ADDR) && ({1'b0, look_off} < SPAN)
                     && ((look_off & ALIGN_MASK) == '0);
        look_idx   = IDXW'(look_off >> SHIFT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign is_ack    = (state_q == ACK);
    assign enter_ack = (state_d == ACK) && !is_ack;
    assign ram_re    = enter_ack && !look_we && look_valid;
    assign ram_we    = is_ack && we_q && look_valid;

    always_comb begin
        src_d      = src_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (enter_ack && !look_we) begin
            src_d = look_valid ? SRC_RAM : SRC_ONES;
        end
        if (err_clear) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        if (is_ack) begin
            if (we_q) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
            // A new error beats a simultaneous clear and records its own address.
            if (!look_valid) begin
                err_d = 1'b1;
                if (!err_q || err_clear) begin
                    err_addr_d = addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            src_q      <= SRC_ZERO;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            src_q      <= src_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    simple_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (look_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        case (src_q)
            SRC_RAM:  mem_rdata = ram_rdata;
            SRC_ONES: mem_rdata = ERR_FILL;
            default:  mem_rdata = '0;
        endcase
    end

    assign mem_ack  = is_ack;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_simple_mem_responder.sv
// Randomised self-checking bench for simple_mem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_simple_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req = 1'b0, mem_we = 1'b0, err_clear = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mem_ack, err;
    logic [31:0] mem_rdata, err_addr, rd_count, wr_count;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic        ack0, err0;
    logic [31:0] rdata0, err_addr0, rd_count0, wr_count0;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] ram_m [256];
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_err_addr = '0;
    int          exp_rd = 0, exp_wr = 0;

    always #5 clk = ~clk;

    simple_mem_responder #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .err(err), .err_addr(err_addr),
        .err_clear(err_clear), .rd_count(rd_count), .wr_count(wr_count)
    );

    simple_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .mem_req(req0), .mem_we(we0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_ack(ack0),
        .mem_rdata(rdata0), .err(err0), .err_addr(err_addr0),
        .err_clear(1'b0), .rd_count(rd_count0), .wr_count(wr_count0)
    );

    function automatic void model_txn(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input bit clr);
        longint a = longint'(addr);
        bit valid = (a >= 0) && (a < 256 * 4) && (a % 4 == 0);
        int idx = int'(a / 4);
        if (!we) begin
            exp_rdata = valid ? ram_m[idx] : 32'hFFFF_FFFF;
            exp_rd++;
        end else begin
            if (valid) ram_m[idx] = wdata;
            exp_wr++;
        end
        if (!valid) begin
            if (!exp_err || clr) exp_err_addr = addr;
            exp_err = 1'b1;
        end else if (clr) begin
            exp_err = 1'b0;
            exp_err_addr = '0;
        end
    endfunction

    task automatic bus_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit clr_at_ack, input bit copy_rdata);
        logic [31:0] wd;
        int lat = 0;
        @(negedge clk);
        wd = copy_rdata ? mem_rdata : wdata;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        @(posedge clk);
        #1;
        // Disturb the bus after acceptance; the DUT must use the captured values.
        mem_we = ~we; mem_addr = $urandom; mem_wdata = $urandom;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (mem_ack) lat = i;
        end
        model_txn(we, addr, wd, clr_at_ack);
        n_chk++;
        if (lat != 1 + W) begin
            n_err++;
            $display("FAIL ack_latency addr=%h got=%0d want=%0d", addr, lat, 1 + W);
        end
        n_chk++;
        if (lat != 0 && mem_rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL ack_rdata addr=%h we=%0b got=%h want=%h", addr, we, mem_rdata, exp_rdata);
        end
        if (clr_at_ack) err_clear = 1'b1;
        mem_req = 1'b0;
        @(negedge clk);
        err_clear = 1'b0;
        n_chk += 5;
        if (mem_ack !== 1'b0) begin n_err++; $display("FAIL ack_pulse got=%b want=0", mem_ack); end
        if (rd_count !== 32'(exp_rd)) begin n_err++; $display("FAIL rd_count got=%0d want=%0d", rd_count, exp_rd); end
        if (wr_count !== 32'(exp_wr)) begin n_err++; $display("FAIL wr_count got=%0d want=%0d", wr_count, exp_wr); end
        if (err !== exp_err) begin n_err++; $display("FAIL err got=%b want=%b", err, exp_err); end
        if (err_addr !== exp_err_addr) begin n_err++; $display("FAIL err_addr got=%h want=%h", err_addr, exp_err_addr); end
        $display("txn we=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%b err_addr=%h rd=%0d wr=%0d",
                 we, addr, wd, lat, mem_rdata, err, err_addr, rd_count, wr_count);
    endtask

    task automatic check_outputs_reset(input string tag);
        n_chk += 6;
        if (mem_ack !== 1'b0) begin n_err++; $display("FAIL %s_ack got=%b want=0", tag, mem_ack); end
        if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL %s_rdata got=%h want=0", tag, mem_rdata); end
        if (err !== 1'b0) begin n_err++; $display("FAIL %s_err got=%b want=0", tag, err); end
        if (err_addr !== 32'h0) begin n_err++; $display("FAIL %s_err_addr got=%h want=0", tag, err_addr); end
        if (rd_count !== 32'h0) begin n_err++; $display("FAIL %s_rd_count got=%0d want=0", tag, rd_count); end
        if (wr_count !== 32'h0) begin n_err++; $display("FAIL %s_wr_count got=%0d want=0", tag, wr_count); end
        $display("%s: ack=%b rdata=%h err=%b rd=%0d wr=%0d", tag, mem_ack, mem_rdata, err, rd_count, wr_count);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        bus_txn(1'b1, 32'h10, 32'hA5A5_0001, 1'b0, 1'b0);
        bus_txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_dma_copy();
        bus_txn(1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0);
        bus_txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
        bus_txn(1'b1, 32'h24, 32'h0, 1'b0, 1'b1);
        bus_txn(1'b0, 32'h24, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        bus_txn(1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
        bus_txn(1'b1, 32'h13, 32'hDEAD_0013, 1'b0, 1'b0);
        bus_txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_err = 1'b0;
        exp_err_addr = '0;
        n_chk += 2;
        if (err !== 1'b0) begin n_err++; $display("FAIL clear_err got=%b want=0", err); end
        if (err_addr !== 32'h0) begin n_err++; $display("FAIL clear_err_addr got=%h want=0", err_addr); end
        $display("err_clear: err=%b err_addr=%h", err, err_addr);
    endtask

    task automatic test_clear_collision();
        bus_txn(1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
        bus_txn(1'b0, 32'h500, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        int          r;
        for (int i = 0; i < 64; i++) bus_txn(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
        bus_txn(1'b1, 32'h3FC, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, 63) * 4);
            else if (r == 7) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            else if (r == 8) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else             a = 32'h3FC;
            w = 1'($urandom_range(0, 1));
            bus_txn(w, a, $urandom, 1'($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        for (int p = 0; p < 4; p++) d[p] = $urandom;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = d[0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_chk++;
            if (ack0 !== 1'b1) begin n_err++; $display("FAIL b2b_ack k=%0d got=%b want=1", k, ack0); end
            if (k % 2 == 1) begin
                n_chk++;
                if (rdata0 !== d[k/2]) begin n_err++; $display("FAIL b2b_rdata k=%0d got=%h want=%h", k, rdata0, d[k/2]); end
            end
            $display("b2b k=%0d ack=%b rdata=%h", k, ack0, rdata0);
            if (k < 7) begin
                we0    = (k % 2 == 1);
                addr0  = 32'h40 + 32'(((k + 1) / 2) * 4);
                wdata0 = (k % 2 == 1) ? d[(k + 1) / 2] : $urandom;
            end else begin
                req0 = 1'b0;
            end
            @(negedge clk);
            n_chk++;
            if (ack0 !== 1'b0) begin n_err++; $display("FAIL b2b_idle k=%0d got=%b want=0", k, ack0); end
        end
        n_chk += 3;
        if (rd_count0 !== 32'd4) begin n_err++; $display("FAIL b2b_rd_count got=%0d want=4", rd_count0); end
        if (wr_count0 !== 32'd4) begin n_err++; $display("FAIL b2b_wr_count got=%0d want=4", wr_count0); end
        if (err0 !== 1'b0) begin n_err++; $display("FAIL b2b_err got=%b want=0", err0); end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h08; mem_wdata = ~ram_m[2];
        @(posedge clk);
        @(negedge clk);
        if (mem_ack) acks++;
        reset_n = 1'b0;
        mem_req = 1'b0;
        #1;
        check_outputs_reset("reset_mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_ack) acks++;
        end
        n_chk++;
        if (acks != 0) begin n_err++; $display("FAIL reset_mid_no_ack got=%0d want=0", acks); end
        exp_rdata = '0; exp_err = 1'b0; exp_err_addr = '0; exp_rd = 0; exp_wr = 0;
        bus_txn(1'b0, 32'h08, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dma_copy();
        test_errors();
        test_clear_collision();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
